// File: rtl/jtopl_pkg.sv
// Shared constants and types for the OPL sound output FIFO stage.
package jtopl_pkg;

    localparam int unsigned SMP_W        = 16;
    localparam int unsigned FADE_W       = 5;
    localparam int unsigned FIFO_AW      = 2;
    localparam int unsigned FIFO_DEPTH   = 1 << FIFO_AW;
    localparam int unsigned FADE_MAX_DEF = 15;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FADE_OUT = 2'd1,
        MUTED    = 2'd2,
        FADE_IN  = 2'd3
    } fade_st_e;

endpackage

// File: rtl/jtopl_sfifo.sv
// Generic synchronous FIFO with sticky overrun flag; push and pop in the
// same cycle are both honoured even when full.
module jtopl_sfifo
    import jtopl_pkg::*;
#(
    parameter int unsigned AW = FIFO_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [SMP_W-1:0] data_i,
    input  logic             pop_i,
    input  logic             ovf_clr_i,
    output logic [SMP_W-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             ovf_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [SMP_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             ovf_q;
    logic             do_push_c;
    logic             do_pop_c;
    logic             drop_c;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop_c  = pop_i & ~empty_o;
    assign do_push_c = push_i & (~full_o | do_pop_c);
    assign drop_c    = push_i & full_o & ~do_pop_c;
    assign data_o    = mem_q[rd_ptr_q];
    assign ovf_o     = ovf_q;

    // Sample storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_c) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers, occupancy and sticky overrun (set beats clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (drop_c)         ovf_q <= 1'b1;
            else if (ovf_clr_i) ovf_q <= 1'b0;
        end
    end

endmodule

// File: rtl/jtopl_snd_fifo.sv
// Per-frame sample capture with volume shift and mute fade, buffered in a
// small FIFO with a valid/ready port toward the audio consumer.
module jtopl_snd_fifo
    import jtopl_pkg::*;
#(
    parameter int unsigned AW       = FIFO_AW,
    parameter int unsigned FADE_MAX = FADE_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cenop,
    input  logic [17:0] slot,
    input  logic [15:0] snd,
    input  logic [2:0]  vol,
    input  logic        mute,
    output logic [15:0] out_sample,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        ovf,
    input  logic        ovf_clr,
    output logic        muted
);

    localparam logic [FADE_W-1:0] FMAX = FADE_W'(FADE_MAX);

    fade_st_e           state_q, state_d;
    logic [FADE_W-1:0]  fade_q, fade_d;
    logic [SMP_W-1:0]   cap_q, cap_d;
    logic               wr_pend_q;
    logic               ft_c;
    logic [5:0]         sum_c;
    logic [FADE_W-1:0]  shift_c;
    logic signed [15:0] snd_s;
    logic signed [15:0] shifted_c;
    logic               fifo_empty;
    logic               unused_full;
    logic               unused_slot;

    assign ft_c        = cenop & slot[0];
    assign snd_s       = snd;
    assign unused_slot = ^slot[17:1];

    // Attenuation = volume + fade, saturated; silence at saturation or when muted
    always_comb begin
        sum_c     = 6'(vol) + 6'(fade_q);
        shift_c   = (sum_c >= 6'(FADE_MAX)) ? FMAX : sum_c[FADE_W-1:0];
        shifted_c = snd_s >>> shift_c;
        cap_d     = ((shift_c == FMAX) || (state_q == MUTED)) ? '0 : SMP_W'(shifted_c);
    end

    // Capture register and one-cycle write request toward the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q     <= '0;
            wr_pend_q <= 1'b0;
        end else begin
            if (ft_c) cap_q <= cap_d;
            wr_pend_q <= ft_c;
        end
    end

    // Fade FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            fade_q  <= '0;
        end else begin
            state_q <= state_d;
            fade_q  <= fade_d;
        end
    end

    // Fade FSM next state; advances only on a frame tick, after capture uses fade_q
    always_comb begin
        state_d = state_q;
        fade_d  = fade_q;
        if (ft_c) begin
            case (state_q)
                RUN: begin
                    if (mute) begin
                        state_d = FADE_OUT;
                        fade_d  = FADE_W'(1);
                    end
                end
                FADE_OUT: begin
                    if (!mute) begin
                        state_d = FADE_IN;
                    end else begin
                        fade_d = fade_q + FADE_W'(1);
                        if (fade_q + FADE_W'(1) >= FMAX) begin
                            state_d = MUTED;
                            fade_d  = FMAX;
                        end
                    end
                end
                MUTED: begin
                    fade_d = FMAX;
                    if (!mute) begin
                        state_d = FADE_IN;
                        fade_d  = FMAX - FADE_W'(1);
                    end
                end
                FADE_IN: begin
                    if (mute) begin
                        state_d = FADE_OUT;
                    end else if (fade_q <= FADE_W'(1)) begin
                        state_d = RUN;
                        fade_d  = '0;
                    end else begin
                        fade_d = fade_q - FADE_W'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                    fade_d  = '0;
                end
            endcase
        end
    end

    // Fade FSM outputs
    always_comb begin
        muted = 1'b0;
        if (state_q == MUTED) muted = 1'b1;
    end

    assign out_valid = ~fifo_empty;

    jtopl_sfifo #(
        .AW (AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (wr_pend_q),
        .data_i    (cap_q),
        .pop_i     (out_valid & out_ready),
        .ovf_clr_i (ovf_clr),
        .data_o    (out_sample),
        .empty_o   (fifo_empty),
        .full_o    (unused_full),
        .ovf_o     (ovf)
    );

endmodule

// File: tb/tb_jtopl_snd_fifo.sv
// Scoreboard bench for jtopl_snd_fifo: expected samples queued at each frame
// tick, compared in order as the consumer handshake pops them.
module tb_jtopl_snd_fifo;

    logic        clk;
    logic        rst_n;
    logic        cenop;
    logic [17:0] slot;
    logic [15:0] snd;
    logic [2:0]  vol;
    logic        mute;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        out_ready;
    logic        ovf;
    logic        ovf_clr;
    logic        muted;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] sb_q [$];

    jtopl_snd_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cenop      (cenop),
        .slot       (slot),
        .snd        (snd),
        .vol        (vol),
        .mute       (mute),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .muted      (muted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Consumer side: a handshake seen here completes at the next rising edge
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n && out_valid && out_ready) begin
            e = 16'hxxxx;
            if (sb_q.size() != 0) e = sb_q.pop_front();
            check("pop", out_sample, e);
        end
    end

    // One frame tick: capture on the first edge, FIFO write on the second
    task automatic tick(input logic [15:0] s, input logic [2:0] v, input logic m,
                        input logic [15:0] exp, input bit keep, input bit rdy_wr);
        snd   = s;
        vol   = v;
        mute  = m;
        cenop = 1'b1;
        slot  = 18'd1;
        if (keep) sb_q.push_back(exp);
        @(posedge clk); #1;
        cenop = 1'b0;
        slot  = 18'd2;
        if (rdy_wr) out_ready = 1'b1;
        @(posedge clk); #1;
        if (rdy_wr) out_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (sb_q.size() == 0 && !out_valid) break;
            @(posedge clk); #1;
        end
        check({tag, "_left"}, 16'(sb_q.size()), 16'd0);
        check({tag, "_valid"}, 16'(out_valid), 16'd0);
    endtask

    task automatic clear_ovf(input string tag);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check(tag, 16'(ovf), 16'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] e;
        rst_n = 1'b0; cenop = 1'b0; slot = 18'd0; snd = 16'h0; vol = 3'd0;
        mute = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        #22;
        check("rst_valid", 16'(out_valid), 16'd0);
        check("rst_sample", out_sample, 16'h0);
        check("rst_ovf", 16'(ovf), 16'd0);
        check("rst_muted", 16'(muted), 16'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ticks with cenop low or slot[0] low must be ignored
        cenop = 1'b0; slot = 18'd1; snd = 16'h5555;
        repeat (3) @(posedge clk);
        #1; cenop = 1'b1; slot = 18'd4;
        repeat (3) @(posedge clk);
        #1; cenop = 1'b0; slot = 18'd0;
        check("no_ft_valid", 16'(out_valid), 16'd0);

        // Reset mid-operation drops out_valid without a clock edge
        for (int k = 1; k <= 3; k++) tick(16'(k), 3'd0, 1'b0, 16'h0, 1'b0, 1'b0);
        check("pre_rst_valid", 16'(out_valid), 16'd1);
        check("pre_rst_head", out_sample, 16'h0001);
        #2; rst_n = 1'b0; #1;
        check("async_rst_valid", 16'(out_valid), 16'd0);
        check("async_rst_sample", out_sample, 16'h0);
        sb_q.delete();
        #10; rst_n = 1'b1;
        @(posedge clk); #1;
        snd = 16'h1234; vol = 3'd0; mute = 1'b0; cenop = 1'b1; slot = 18'd1;
        sb_q.push_back(16'h1234);
        @(posedge clk); #1;
        cenop = 1'b0; slot = 18'd2;
        check("lat1_valid", 16'(out_valid), 16'd0);
        @(posedge clk); #1;
        check("lat2_valid", 16'(out_valid), 16'd1);
        check("lat2_head", out_sample, 16'h1234);
        drain("t1");

        // Gain: arithmetic right shift, no rounding
        tick(16'hFC18, 3'd3, 1'b0, 16'hFF83, 1'b1, 1'b0);
        tick(16'hFFFF, 3'd1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        tick(16'h8000, 3'd7, 1'b0, 16'hFF00, 1'b1, 1'b0);
        tick(16'h7FFF, 3'd7, 1'b0, 16'h00FF, 1'b1, 1'b0);
        tick(16'h1234, 3'd0, 1'b0, 16'h1234, 1'b1, 1'b0);
        drain("t2");

        // Overrun: fifth sample dropped, order preserved, clear works
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) tick(16'(k), 3'd0, 1'b0, 16'(k), 1'b1, 1'b0);
        check("ovf_at4", 16'(ovf), 16'd0);
        tick(16'd5, 3'd0, 1'b0, 16'h0, 1'b0, 1'b0);
        check("ovf_at5", 16'(ovf), 16'd1);
        check("stall_head", out_sample, 16'h0001);
        drain("t3");
        check("ovf_sticky", 16'(ovf), 16'd1);
        clear_ovf("ovf_clr");

        // Set and clear in the same cycle: set wins
        out_ready = 1'b0;
        for (int k = 6; k <= 9; k++) tick(16'(k), 3'd0, 1'b0, 16'(k), 1'b1, 1'b0);
        ovf_clr = 1'b1;
        tick(16'd10, 3'd0, 1'b0, 16'h0, 1'b0, 1'b0);
        ovf_clr = 1'b0;
        check("ovf_set_wins", 16'(ovf), 16'd1);
        drain("t3b");
        clear_ovf("ovf_clr2");

        // Full with simultaneous push and pop
        out_ready = 1'b0;
        for (int k = 11; k <= 14; k++) tick(16'(k), 3'd0, 1'b0, 16'(k), 1'b1, 1'b0);
        tick(16'd15, 3'd0, 1'b0, 16'd15, 1'b1, 1'b1);
        check("full_pp_ovf", 16'(ovf), 16'd0);
        check("full_pp_head", out_sample, 16'd12);
        tick(16'd16, 3'd0, 1'b0, 16'h0, 1'b0, 1'b0);
        check("full_pp_still4", 16'(ovf), 16'd1);
        drain("t4");
        clear_ovf("ovf_clr3");

        // Fade out to silence
        for (int k = 0; k < 16; k++) begin
            e = (k < 15) ? 16'(16'h4000 >> k) : 16'h0000;
            tick(16'h4000, 3'd0, 1'b1, e, 1'b1, 1'b0);
            if (k == 13) check("fade_out_not_muted", 16'(muted), 16'd0);
        end
        check("muted_on", 16'(muted), 16'd1);
        drain("t5a");
        tick(16'h4000, 3'd0, 1'b1, 16'h0000, 1'b1, 1'b0);
        check("muted_hold", 16'(muted), 16'd1);
        drain("t5b");

        // Fade back in: the tick that sees mute low still captures in MUTED
        for (int j = 0; j < 16; j++) begin
            e = (j == 0) ? 16'h0000 : 16'(16'h4000 >> (15 - j));
            tick(16'h4000, 3'd0, 1'b0, e, 1'b1, 1'b0);
            if (j == 0) check("muted_off", 16'(muted), 16'd0);
        end
        drain("t5c");
        tick(16'h4000, 3'd2, 1'b0, 16'h1000, 1'b1, 1'b0);
        drain("t5d");

        // Fade reversal after four fade-out ticks
        for (int k = 0; k < 4; k++) tick(16'h4000, 3'd0, 1'b1, 16'(16'h4000 >> k), 1'b1, 1'b0);
        tick(16'h4000, 3'd0, 1'b0, 16'h0400, 1'b1, 1'b0);
        tick(16'h4000, 3'd0, 1'b0, 16'h0400, 1'b1, 1'b0);
        tick(16'h4000, 3'd0, 1'b0, 16'h0800, 1'b1, 1'b0);
        tick(16'h4000, 3'd0, 1'b0, 16'h1000, 1'b1, 1'b0);
        tick(16'h4000, 3'd0, 1'b0, 16'h2000, 1'b1, 1'b0);
        tick(16'h4000, 3'd0, 1'b0, 16'h4000, 1'b1, 1'b0);
        tick(16'h4000, 3'd0, 1'b0, 16'h4000, 1'b1, 1'b0);
        drain("t6");
        check("rev_muted", 16'(muted), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
